// File: rtl/ddr3_frame_fetch.sv
// ---------------------------------------------------------------------------
// ddr3_frame_fetch
//
// Fetches one frame of 128-bit words from a DDR3 controller's Avalon read
// port and streams the returned beats into a first-word-fall-through FIFO.
// Read bursts are only issued when the FIFO is guaranteed to have room for
// every word already requested plus one more full burst, so in normal
// operation the FIFO never overflows.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle pulse that begins a frame fetch
//   frame_base          frame start address (128-bit word units)
//   frame_words         frame length in words (0 = start ignored)
//   local_init_done     DDR3 controller calibrated
//   busy                fetch in progress (not IDLE)
//   avl_*               Avalon read request / read data interface
//   fifo_rd             consumer pop
//   fifo_dout           head word, valid while fifo_empty = 0
//   fifo_empty          FIFO holds no words
//   fifo_level          number of words stored
//   overflow            sticky: beat dropped because the FIFO was full
//   underflow           sticky: pop attempted on an empty FIFO
// ---------------------------------------------------------------------------
module ddr3_frame_fetch #(
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [25:0]                   frame_base,
    input  logic [19:0]                   frame_words,
    input  logic                          local_init_done,
    output logic                          busy,
    input  logic                          avl_ready,
    output logic                          avl_burstbegin,
    output logic                          avl_read_req,
    output logic [25:0]                   avl_addr,
    output logic [2:0]                    avl_size,
    input  logic                          avl_rdata_valid,
    input  logic [127:0]                  avl_rdata,
    input  logic                          fifo_rd,
    output logic [127:0]                  fifo_dout,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int OW = LW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [2:0]  BURST_SIZE  = 3'(BURST_LEN);
    localparam logic [19:0] BURST_L20   = 20'(BURST_LEN);
    localparam logic [31:0] BURST_L32   = 32'(BURST_LEN);
    localparam logic [31:0] DEPTH_L32   = 32'(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_LW  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [OW-1:0] OUT_ONE   = OW'(1'b1);

    // Size of the next burst: a full burst, or the tail of the frame.
    function automatic logic [2:0] burst_size(input logic [19:0] remaining);
        logic [2:0] sz;
        if (remaining < BURST_L20) begin
            sz = remaining[2:0];
        end else begin
            sz = BURST_SIZE;
        end
        return sz;
    endfunction

    // Fetch control state
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          busy_r;
    logic [19:0]   remaining_r;
    logic [19:0]   remaining_nxt_s;
    logic [25:0]   addr_r;
    logic [OW-1:0] outstanding_r;
    logic [OW-1:0] outstanding_sum_s;
    logic [OW-1:0] outstanding_nxt_s;

    // Avalon request registers
    logic          req_r;
    logic          burstbegin_r;
    logic [25:0]   req_addr_r;
    logic [2:0]    req_size_r;

    // FIFO storage and bookkeeping
    logic [127:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          empty_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          start_ok_s;
    logic          accept_s;
    logic          credit_ok_s;
    logic          present_s;
    logic          beat_dec_s;
    logic          fifo_full_s;
    logic          fifo_is_empty_s;
    logic          pop_s;
    logic          push_s;
    logic          overflow_set_s;
    logic          underflow_set_s;

    assign start_ok_s  = (state_r == ST_IDLE) & start & local_init_done
                         & (frame_words != 20'd0);
    assign accept_s    = req_r & avl_ready;
    // Room must exist for everything in flight plus one full burst, so a
    // short tail burst uses the same conservative credit as a full one.
    assign credit_ok_s = (32'(level_r) + 32'(outstanding_r) + BURST_L32) <= DEPTH_L32;
    // A new request is never raised while one is still presented, which also
    // guarantees an idle cycle after every acceptance.
    assign present_s   = (state_r == ST_REQ) & ~req_r & (remaining_r != 20'd0)
                         & credit_ok_s;
    // Beats with nothing outstanding are stray; the counter saturates at 0.
    assign beat_dec_s  = avl_rdata_valid & (outstanding_r != {OW{1'b0}});

    assign fifo_full_s     = (level_r == DEPTH_LW);
    assign fifo_is_empty_s = (level_r == {LW{1'b0}});
    assign pop_s           = fifo_rd & ~fifo_is_empty_s;
    // A pop in the same cycle frees the slot a full FIFO needs for the write.
    assign push_s          = avl_rdata_valid & (~fifo_full_s | pop_s);
    assign overflow_set_s  = avl_rdata_valid & fifo_full_s & ~fifo_rd;
    assign underflow_set_s = fifo_rd & fifo_is_empty_s;

    // Remaining-word and outstanding-beat updates for this cycle.
    always_comb begin
        remaining_nxt_s   = remaining_r;
        outstanding_sum_s = outstanding_r;
        outstanding_nxt_s = outstanding_r;
        if (accept_s) begin
            remaining_nxt_s   = remaining_r - 20'(req_size_r);
            outstanding_sum_s = outstanding_r + OW'(req_size_r);
        end else begin
            remaining_nxt_s   = remaining_r;
            outstanding_sum_s = outstanding_r;
        end
        if (beat_dec_s) begin
            outstanding_nxt_s = outstanding_sum_s - OUT_ONE;
        end else begin
            outstanding_nxt_s = outstanding_sum_s;
        end
    end

    // Next-state decode for the fetch controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (accept_s && (remaining_nxt_s == 20'd0)) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (outstanding_nxt_s == {OW{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next FIFO occupancy from this cycle's push and pop.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Fetch controller registers: state, frame progress, in-flight count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            remaining_r   <= 20'd0;
            addr_r        <= 26'd0;
            outstanding_r <= {OW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            outstanding_r <= outstanding_nxt_s;
            if (start_ok_s) begin
                remaining_r <= frame_words;
                addr_r      <= frame_base;
            end else if (accept_s) begin
                remaining_r <= remaining_nxt_s;
                addr_r      <= addr_r + 26'(req_size_r);
            end else begin
                remaining_r <= remaining_r;
                addr_r      <= addr_r;
            end
        end
    end

    // Avalon request: raise, hold unchanged while not ready, drop on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_r        <= 1'b0;
            burstbegin_r <= 1'b0;
            req_addr_r   <= 26'd0;
            req_size_r   <= 3'd0;
        end else begin
            if (accept_s) begin
                req_r        <= 1'b0;
                burstbegin_r <= 1'b0;
            end else if (req_r) begin
                req_r        <= 1'b1;
                burstbegin_r <= 1'b0;
            end else if (present_s) begin
                req_r        <= 1'b1;
                burstbegin_r <= 1'b1;
                req_addr_r   <= addr_r;
                req_size_r   <= burst_size(remaining_r);
            end else begin
                req_r        <= 1'b0;
                burstbegin_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            empty_r <= (level_nxt_s == {LW{1'b0}});
            // A new error in the same cycle as a start still gets recorded.
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (start_ok_s) begin
                overflow_r <= 1'b0;
            end
            if (underflow_set_s) begin
                underflow_r <= 1'b1;
            end else if (start_ok_s) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // FIFO data storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= avl_rdata;
        end
    end

    assign busy           = busy_r;
    assign avl_read_req   = req_r;
    assign avl_burstbegin = burstbegin_r;
    assign avl_addr       = req_addr_r;
    assign avl_size       = req_size_r;
    assign fifo_dout      = mem_r[rd_ptr_r];
    assign fifo_empty     = empty_r;
    assign fifo_level     = level_r;
    assign overflow       = overflow_r;
    assign underflow      = underflow_r;

endmodule

// File: tb/tb_ddr3_frame_fetch.sv
// ---------------------------------------------------------------------------
// tb_ddr3_frame_fetch
//
// Randomised bench for ddr3_frame_fetch. A memory responder returns beats
// for accepted bursts with random latency, the consumer pops randomly, and a
// queue-based reference model tracks expected FIFO contents, request
// addresses/sizes, busy and the sticky flags.
// ---------------------------------------------------------------------------
module tb_ddr3_frame_fetch;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [25:0]  frame_base;
    logic [19:0]  frame_words;
    logic         local_init_done;
    logic         busy;
    logic         avl_ready;
    logic         avl_burstbegin;
    logic         avl_read_req;
    logic [25:0]  avl_addr;
    logic [2:0]   avl_size;
    logic         avl_rdata_valid;
    logic [127:0] avl_rdata;
    logic         fifo_rd;
    logic [127:0] fifo_dout;
    logic         fifo_empty;
    logic [6:0]   fifo_level;
    logic         overflow;
    logic         underflow;

    always #5 clk = ~clk;

    ddr3_frame_fetch #(.BURST_LEN(4), .FIFO_DEPTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_base(frame_base),
        .frame_words(frame_words), .local_init_done(local_init_done),
        .busy(busy), .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
        .avl_read_req(avl_read_req), .avl_addr(avl_addr), .avl_size(avl_size),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
    );

    int checks_r = 0;
    int errors_r = 0;

    // Reference model state
    logic [127:0] model_q[$];
    logic [25:0]  pend_q[$];
    int           outstanding_m;
    bit           busy_m, ovf_m, udf_m;
    int           req_idx, exp_words;
    logic [25:0]  exp_base;
    logic [31:0]  salt;
    bit           held_prev;
    logic [25:0]  prev_addr;
    logic [2:0]   prev_size;
    int           pres_cycles, last_pres_cycles;

    // Stimulus knobs
    bit auto_resp, auto_pop;
    int ready_pct, pop_pct, ready_low_left;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [25:0] a);
        return {salt, {6'd0, a}, ~{6'd0, a}, salt ^ 32'h5A5A_5A5A};
    endfunction

    // One clock cycle: drive inputs, update the model with the events that
    // happen at the coming edge, advance, then compare registered outputs.
    task automatic tick();
        bit          acc, pop_en, full_pre, start_acc, resp_beat;
        int          exp_sz;
        logic [25:0] ea;
        resp_beat = 1'b0;
        if (auto_resp) begin
            if (pend_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                avl_rdata_valid = 1'b1;
                avl_rdata       = mk_data(pend_q[0]);
                resp_beat       = 1'b1;
            end else begin
                avl_rdata_valid = 1'b0;
                avl_rdata       = 128'd0;
            end
        end
        if (auto_pop) fifo_rd = (model_q.size() != 0) && ($urandom_range(0, 99) < pop_pct);
        if (avl_read_req && ready_low_left > 0) begin
            avl_ready = 1'b0;
            ready_low_left--;
        end else begin
            avl_ready = ($urandom_range(0, 99) < ready_pct);
        end

        // request-side protocol checks for the current cycle
        acc = avl_read_req && avl_ready;
        if (avl_read_req) begin
            check_eq("burstbegin", avl_burstbegin, !held_prev);
            if (held_prev) begin
                check_eq("hold_addr", avl_addr, prev_addr);
                check_eq("hold_size", avl_size, prev_size);
            end
            pres_cycles++;
        end else begin
            check_eq("burstbegin_idle", avl_burstbegin, 1'b0);
            pres_cycles = 0;
        end
        if (!busy_m) check_eq("req_while_idle", avl_read_req, 1'b0);

        start_acc = start && !busy_m && local_init_done && (frame_words != 20'd0);
        if (start_acc) begin
            busy_m    = 1'b1;
            exp_base  = frame_base;
            exp_words = int'(frame_words);
            req_idx   = 0;
            ovf_m     = 1'b0;
            udf_m     = 1'b0;
        end

        // FIFO side
        full_pre = (model_q.size() >= 64);
        pop_en   = fifo_rd && (model_q.size() != 0);
        if (fifo_rd) begin
            if (model_q.size() == 0) udf_m = 1'b1;
            else check_eq("fifo_dout", fifo_dout, model_q[0]);
        end
        if (pop_en) void'(model_q.pop_front());
        if (avl_rdata_valid) begin
            if (resp_beat) void'(pend_q.pop_front());
            if (!full_pre || pop_en) model_q.push_back(avl_rdata);
            else ovf_m = 1'b1;
            if (outstanding_m > 0) outstanding_m--;
        end

        if (acc) begin
            if (req_idx * 4 >= exp_words) begin
                check_eq("req_count_excess", req_idx, (exp_words + 3) / 4 - 1);
            end else begin
                exp_sz = (exp_words - req_idx * 4 < 4) ? (exp_words - req_idx * 4) : 4;
                ea = exp_base + 26'(req_idx * 4);
                check_eq("req_addr", avl_addr, ea);
                check_eq("req_size", avl_size, exp_sz);
                for (int i = 0; i < exp_sz; i++) pend_q.push_back(ea + 26'(i));
                outstanding_m += exp_sz;
            end
            req_idx++;
            last_pres_cycles = pres_cycles;
            pres_cycles = 0;
        end
        held_prev = avl_read_req && !acc;
        prev_addr = avl_addr;
        prev_size = avl_size;

        @(posedge clk);
        #1;
        if (busy_m && (req_idx * 4 >= exp_words) && outstanding_m == 0) busy_m = 1'b0;

        check_eq("busy", busy, busy_m);
        check_eq("level", fifo_level, model_q.size());
        check_eq("empty", fifo_empty, model_q.size() == 0);
        check_eq("overflow", overflow, ovf_m);
        check_eq("underflow", underflow, udf_m);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; avl_rdata_valid = 1'b0; fifo_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete(); pend_q.delete();
        outstanding_m = 0; busy_m = 1'b0; ovf_m = 1'b0; udf_m = 1'b0;
        req_idx = 0; exp_words = 0; held_prev = 1'b0; pres_cycles = 0;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_read_req", avl_read_req, 1'b0);
        check_eq("rst_burstbegin", avl_burstbegin, 1'b0);
        check_eq("rst_addr", avl_addr, 26'd0);
        check_eq("rst_size", avl_size, 3'd0);
        check_eq("rst_empty", fifo_empty, 1'b1);
        check_eq("rst_level", fifo_level, 7'd0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_underflow", underflow, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_m && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_in_budget", busy_m, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        auto_pop = 1'b1; pop_pct = 100;
        while (model_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drained", fifo_level, 7'd0);
    endtask

    task automatic issue_start(input logic [25:0] base, input int words);
        frame_base = base; frame_words = 20'(words); local_init_done = 1'b1;
        salt = $urandom();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [25:0] base, input int words, input int rdy, input int pp);
        ready_pct = rdy; pop_pct = pp; auto_resp = 1'b1; auto_pop = 1'b1;
        issue_start(base, words);
        wait_idle(3000);
        check_eq("req_count", req_idx, (words + 3) / 4);
    endtask

    initial begin
        logic [127:0] d;
        reset = 1'b1; start = 1'b0; frame_base = 26'd0; frame_words = 20'd0;
        local_init_done = 1'b1; avl_ready = 1'b1; avl_rdata_valid = 1'b0;
        avl_rdata = 128'd0; fifo_rd = 1'b0; salt = 32'h1234_5678;
        auto_resp = 1'b1; auto_pop = 1'b0; ready_pct = 100; pop_pct = 50;
        ready_low_left = 0; last_pres_cycles = 0;
        prev_addr = 26'd0; prev_size = 3'd0;
        do_reset();

        // underflow and ignored starts
        auto_pop = 1'b0;
        fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
        check_eq("underflow_set", underflow, 1'b1);
        frame_base = 26'h10; frame_words = 20'd8; local_init_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick();
        check_eq("ignored_no_init", busy, 1'b0);
        local_init_done = 1'b1; frame_words = 20'd0;
        start = 1'b1; tick(); start = 1'b0; tick();
        check_eq("ignored_zero_words", busy, 1'b0);
        check_eq("underflow_sticky", underflow, 1'b1);

        // two full bursts, always ready
        run_frame(26'h100, 8, 100, 60);
        check_eq("underflow_cleared", underflow, 1'b0);
        drain(200);

        // 4,4,2 split with random ready and an ignored start while busy
        ready_pct = 70; pop_pct = 50; auto_pop = 1'b1;
        issue_start(26'h0, 10);
        repeat (3) tick();
        frame_base = 26'h2000; frame_words = 20'd4; start = 1'b1; tick(); start = 1'b0;
        wait_idle(3000);
        check_eq("req_count_10", req_idx, 3);
        drain(200);

        // ready held low for five cycles on the first request
        ready_low_left = 5;
        run_frame(26'h40, 4, 100, 50);
        check_eq("held_req_cycles", last_pres_cycles, 6);
        drain(200);

        // address wrap
        run_frame(26'h3FFFFFE, 8, 80, 50);
        drain(200);

        // credit limit with no consumer
        auto_resp = 1'b1; auto_pop = 1'b0; fifo_rd = 1'b0; ready_pct = 100;
        issue_start(26'h1000, 100);
        repeat (300) tick();
        check_eq("credit_bursts", req_idx, 16);
        check_eq("full_level", fifo_level, 7'd64);
        check_eq("no_overflow", overflow, 1'b0);
        auto_resp = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        avl_rdata_valid = 1'b1; avl_rdata = d; tick();
        check_eq("overflow_set", overflow, 1'b1);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        fifo_rd = 1'b1; avl_rdata = d; tick();
        avl_rdata_valid = 1'b0; fifo_rd = 1'b0;
        check_eq("full_swap_level", fifo_level, 7'd64);
        auto_resp = 1'b1;
        fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
        repeat (20) tick();
        check_eq("one_pop_no_release", req_idx, 16);
        fifo_rd = 1'b1; repeat (3) tick(); fifo_rd = 1'b0;
        repeat (20) tick();
        check_eq("four_pop_release", req_idx, 17);
        auto_pop = 1'b1; pop_pct = 70;
        wait_idle(4000);
        check_eq("req_count_100", req_idx, 25);
        drain(200);

        // random frames
        for (int k = 0; k < 4; k++) begin
            run_frame(26'($urandom()), $urandom_range(1, 60),
                      $urandom_range(40, 100), $urandom_range(30, 100));
            drain(300);
        end

        // reset mid-burst, then a stray beat while idle
        auto_pop = 1'b0; fifo_rd = 1'b0; ready_pct = 100;
        issue_start(26'h500, 40);
        repeat (12) tick();
        do_reset();
        auto_resp = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        avl_rdata_valid = 1'b1; avl_rdata = d; tick(); avl_rdata_valid = 1'b0;
        check_eq("stray_level", fifo_level, 7'd1);
        check_eq("stray_idle", busy, 1'b0);
        drain(20);
        auto_resp = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
